// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
//   req    : request valid, held with addr until the response cycle
//   addr   : request address
//   rvalid : response valid; completes the outstanding request
//   rdata  : instruction word, meaningful when rvalid=1
interface if_fetch_if;
   logic        req;
   logic [31:0] addr;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, output addr, input rvalid, input rdata);
   modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight and
// presents each returned instruction as a registered pc/inst/valid triple.
// Handles IF/ID back-pressure (stall) and branch redirects (flush), dropping
// any response that belongs to a squashed request.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   stall           : IF/ID cannot accept; hold outputs
//   flush, flush_pc : redirect request and target
//   imem            : instruction-memory bus (master side)
//   if_pc, if_inst  : fetched instruction address / word (registered)
//   if_valid        : if_pc/if_inst hold a real instruction
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   if_fetch_if.master  imem,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_valid
);

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_HOLD = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;

   logic [1:0]      state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt;
   logic [XLEN-1:0] pend_pc, pend_pc_nxt;
   logic [XLEN-1:0] buf_pc, buf_pc_nxt;
   logic [XLEN-1:0] buf_inst, buf_inst_nxt;
   logic [XLEN-1:0] if_pc_nxt, if_inst_nxt;
   logic            if_valid_nxt;

   // Request is live in REQ and DROP; DROP keeps the squashed address until
   // its response arrives so the memory sees a stable request.
   assign imem.req  = ((state == S_REQ) || (state == S_DROP)) && !rst;
   assign imem.addr = pc;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_REQ;
      else     state <= state_nxt;
   end

   // Next-state and datapath next values
   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      pend_pc_nxt  = pend_pc;
      buf_pc_nxt   = buf_pc;
      buf_inst_nxt = buf_inst;
      if_pc_nxt    = if_pc;
      if_inst_nxt  = if_inst;
      if_valid_nxt = if_valid;

      if (flush) begin
         if_valid_nxt = 1'b0;
         // No request in flight (HOLD) or the one in flight ends now: the
         // redirect target can be fetched next cycle. Otherwise wait in DROP.
         if ((state == S_HOLD) || imem.rvalid) begin
            pc_nxt    = flush_pc;
            state_nxt = S_REQ;
         end else begin
            pend_pc_nxt = flush_pc;
            state_nxt   = S_DROP;
         end
      end else begin
         case (state)
            S_REQ: begin
               if (imem.rvalid) begin
                  pc_nxt = pc + XLEN'(4);
                  if (stall) begin
                     buf_pc_nxt   = pc;
                     buf_inst_nxt = imem.rdata;
                     state_nxt    = S_HOLD;
                  end else begin
                     if_pc_nxt    = pc;
                     if_inst_nxt  = imem.rdata;
                     if_valid_nxt = 1'b1;
                  end
               end else if (!stall) begin
                  if_valid_nxt = 1'b0;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  if_pc_nxt    = buf_pc;
                  if_inst_nxt  = buf_inst;
                  if_valid_nxt = 1'b1;
                  state_nxt    = S_REQ;
               end
            end
            S_DROP: begin
               if (imem.rvalid) begin
                  pc_nxt    = pend_pc;
                  state_nxt = S_REQ;
               end
            end
            default: state_nxt = S_REQ;
         endcase
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         pend_pc  <= '0;
         buf_pc   <= '0;
         buf_inst <= '0;
         if_pc    <= '0;
         if_inst  <= '0;
         if_valid <= 1'b0;
      end else begin
         pc       <= pc_nxt;
         pend_pc  <= pend_pc_nxt;
         buf_pc   <= buf_pc_nxt;
         buf_inst <= buf_inst_nxt;
         if_pc    <= if_pc_nxt;
         if_inst  <= if_inst_nxt;
         if_valid <= if_valid_nxt;
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch. Inputs change 1 time unit after each
// rising edge; registered outputs are checked there, combinational request
// signals 1 unit later once the new inputs have settled.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        flush;
   logic [31:0] flush_pc;
   logic [31:0] if_pc, if_inst;
   logic        if_valid;

   logic        stall2, flush2;
   logic [31:0] flush_pc2;
   logic [31:0] if_pc2, if_inst2;
   logic        if_valid2;

   int total = 0;
   int bad   = 0;

   if_fetch_if bus();
   if_fetch_if bus2();

   always #5 clk = ~clk;

   if_fetch u_dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
      .imem(bus), .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
   );

   if_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
      .clk(clk), .rst(rst), .stall(stall2), .flush(flush2), .flush_pc(flush_pc2),
      .imem(bus2), .if_pc(if_pc2), .if_inst(if_inst2), .if_valid(if_valid2)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[23:0], 8'h13};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] a;
      rst = 1'b1; stall = 1'b0; flush = 1'b0; flush_pc = '0;
      bus.rvalid = 1'b0; bus.rdata = '0;
      repeat (3) tick();
      total++;
      if (bus.req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin
         bad++;
         $display("FAIL reset_state got req=%b valid=%b pc=%h inst=%h exp 0/0/0/0",
                  bus.req, if_valid, if_pc, if_inst);
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = 32'(i * 4);
         bus.rvalid = 1'b1; bus.rdata = inst_of(a);
         #1;
         total++;
         if (bus.req !== 1'b1 || bus.addr !== a) begin
            bad++;
            $display("FAIL reset_addr got req=%b addr=%h exp req=1 addr=%h", bus.req, bus.addr, a);
         end
         tick();
         total++;
         if (if_valid !== 1'b1 || if_pc !== a || if_inst !== inst_of(a)) begin
            bad++;
            $display("FAIL reset_out got valid=%b pc=%h inst=%h exp 1 %h %h",
                     if_valid, if_pc, if_inst, a, inst_of(a));
         end
      end
   endtask

   task automatic test_wait_states();
      // Request to 0xC; response on its third cycle gives two bubbles.
      for (int c = 0; c < 3; c++) begin
         bus.rvalid = (c == 2); bus.rdata = inst_of(32'hC);
         #1;
         total++;
         if (bus.req !== 1'b1 || bus.addr !== 32'hC) begin
            bad++;
            $display("FAIL wait_addr got req=%b addr=%h exp req=1 addr=0000000c", bus.req, bus.addr);
         end
         tick();
         if (c < 2) begin
            total++;
            if (if_valid !== 1'b0) begin
               bad++;
               $display("FAIL wait_bubble got valid=%b exp 0", if_valid);
            end
         end else begin
            total++;
            if (if_valid !== 1'b1 || if_pc !== 32'hC || if_inst !== inst_of(32'hC)) begin
               bad++;
               $display("FAIL wait_out got valid=%b pc=%h inst=%h exp 1 0000000c %h",
                        if_valid, if_pc, if_inst, inst_of(32'hC));
            end
         end
      end
      bus.rvalid = 1'b0;
      #1;
      total++;
      if (bus.req !== 1'b1 || bus.addr !== 32'h10) begin
         bad++;
         $display("FAIL wait_next got req=%b addr=%h exp req=1 addr=00000010", bus.req, bus.addr);
      end
      tick();
      total++;
      if (if_valid !== 1'b0) begin
         bad++;
         $display("FAIL wait_once got valid=%b exp 0", if_valid);
      end
   endtask

   task automatic test_stall();
      // Response for 0x10 arrives with stall=1; stall held for 4 cycles.
      for (int c = 0; c < 4; c++) begin
         stall = 1'b1; bus.rvalid = (c == 0); bus.rdata = 32'hDEAD_BEEF;
         #1;
         if (c > 0) begin
            total++;
            if (bus.req !== 1'b0) begin
               bad++;
               $display("FAIL stall_noreq got req=%b exp 0", bus.req);
            end
         end
         tick();
         total++;
         if (if_valid !== 1'b0 || if_pc !== 32'hC || if_inst !== inst_of(32'hC)) begin
            bad++;
            $display("FAIL stall_hold got valid=%b pc=%h inst=%h exp 0 0000000c %h",
                     if_valid, if_pc, if_inst, inst_of(32'hC));
         end
      end
      stall = 1'b0; bus.rvalid = 1'b0;
      tick();
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_inst !== 32'hDEAD_BEEF) begin
         bad++;
         $display("FAIL stall_resume got valid=%b pc=%h inst=%h exp 1 00000010 deadbeef",
                  if_valid, if_pc, if_inst);
      end
      // Stall with no response must hold the valid instruction, not bubble.
      stall = 1'b1;
      #1;
      total++;
      if (bus.req !== 1'b1 || bus.addr !== 32'h14) begin
         bad++;
         $display("FAIL stall_nextreq got req=%b addr=%h exp req=1 addr=00000014", bus.req, bus.addr);
      end
      tick();
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'h10) begin
         bad++;
         $display("FAIL stall_keep got valid=%b pc=%h exp 1 00000010", if_valid, if_pc);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      stall = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = 32'h14 + 32'(i * 4);
         bus.rvalid = 1'b1; bus.rdata = inst_of(a);
         #1;
         total++;
         if (bus.addr !== a) begin
            bad++;
            $display("FAIL b2b_addr got addr=%h exp %h", bus.addr, a);
         end
         tick();
         total++;
         if (if_valid !== 1'b1 || if_pc !== a || if_inst !== inst_of(a)) begin
            bad++;
            $display("FAIL b2b_out got valid=%b pc=%h inst=%h exp 1 %h %h",
                     if_valid, if_pc, if_inst, a, inst_of(a));
         end
      end
   endtask

   task automatic test_flush_outstanding();
      // Request to 0x20 waits; two flushes while it is squashed, last target wins.
      bus.rvalid = 1'b0;
      tick();
      for (int c = 0; c < 2; c++) begin
         flush = 1'b1; flush_pc = (c == 0) ? 32'h80 : 32'h100;
         #1;
         total++;
         if (bus.req !== 1'b1 || bus.addr !== 32'h20) begin
            bad++;
            $display("FAIL flush_hold_addr got req=%b addr=%h exp req=1 addr=00000020", bus.req, bus.addr);
         end
         tick();
         total++;
         if (if_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_invalid got valid=%b exp 0", if_valid);
         end
      end
      flush = 1'b0; bus.rvalid = 1'b1; bus.rdata = inst_of(32'h20);
      tick();
      total++;
      if (if_valid !== 1'b0 || if_pc === 32'h20) begin
         bad++;
         $display("FAIL flush_drop got valid=%b pc=%h exp valid=0 pc!=00000020", if_valid, if_pc);
      end
      bus.rdata = inst_of(32'h100);
      #1;
      total++;
      if (bus.req !== 1'b1 || bus.addr !== 32'h100) begin
         bad++;
         $display("FAIL flush_target got req=%b addr=%h exp req=1 addr=00000100", bus.req, bus.addr);
      end
      tick();
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== inst_of(32'h100)) begin
         bad++;
         $display("FAIL flush_first got valid=%b pc=%h inst=%h exp 1 00000100 %h",
                  if_valid, if_pc, if_inst, inst_of(32'h100));
      end
   endtask

   task automatic test_flush_stall_rvalid();
      flush = 1'b1; stall = 1'b1; flush_pc = 32'h200;
      bus.rvalid = 1'b1; bus.rdata = inst_of(32'h104);
      tick();
      total++;
      if (if_valid !== 1'b0 || if_pc !== 32'h100) begin
         bad++;
         $display("FAIL fsr_out got valid=%b pc=%h exp 0 00000100", if_valid, if_pc);
      end
      flush = 1'b0; stall = 1'b0; bus.rvalid = 1'b0;
      #1;
      total++;
      if (bus.req !== 1'b1 || bus.addr !== 32'h200) begin
         bad++;
         $display("FAIL fsr_target got req=%b addr=%h exp req=1 addr=00000200", bus.req, bus.addr);
      end
      tick();
      bus.rvalid = 1'b1; bus.rdata = inst_of(32'h200);
      tick();
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'h200) begin
         bad++;
         $display("FAIL fsr_first got valid=%b pc=%h exp 1 00000200", if_valid, if_pc);
      end
      // Flush out of HOLD discards the buffered 0x204.
      stall = 1'b1; bus.rdata = inst_of(32'h204);
      tick();
      flush = 1'b1; flush_pc = 32'h300; bus.rvalid = 1'b0;
      tick();
      total++;
      if (if_valid !== 1'b0) begin
         bad++;
         $display("FAIL hold_flush got valid=%b exp 0", if_valid);
      end
      flush = 1'b0; stall = 1'b0;
      #1;
      total++;
      if (bus.req !== 1'b1 || bus.addr !== 32'h300) begin
         bad++;
         $display("FAIL hold_flush_target got req=%b addr=%h exp req=1 addr=00000300", bus.req, bus.addr);
      end
      tick();
      total++;
      if (if_valid !== 1'b0 || if_pc !== 32'h200) begin
         bad++;
         $display("FAIL hold_flush_discard got valid=%b pc=%h exp 0 00000200", if_valid, if_pc);
      end
   endtask

   task automatic test_reset_mid_request();
      rst = 1'b1;
      #1;
      total++;
      if (bus.req !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_req got req=%b exp 0", bus.req);
      end
      tick();
      total++;
      if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin
         bad++;
         $display("FAIL rst_mid_out got valid=%b pc=%h inst=%h exp 0 0 0", if_valid, if_pc, if_inst);
      end
      tick();
   endtask

   task automatic test_wrap();
      logic [31:0] a;
      rst = 1'b0; bus.rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = 32'hFFFF_FFF8 + 32'(i * 4);
         bus2.rvalid = 1'b1; bus2.rdata = inst_of(a);
         #1;
         total++;
         if (bus2.req !== 1'b1 || bus2.addr !== a) begin
            bad++;
            $display("FAIL wrap_addr got req=%b addr=%h exp req=1 addr=%h", bus2.req, bus2.addr, a);
         end
         tick();
         total++;
         if (if_valid2 !== 1'b1 || if_pc2 !== a || if_inst2 !== inst_of(a)) begin
            bad++;
            $display("FAIL wrap_out got valid=%b pc=%h inst=%h exp 1 %h %h",
                     if_valid2, if_pc2, if_inst2, a, inst_of(a));
         end
      end
      bus2.rvalid = 1'b0;
   endtask

   initial begin
      stall2 = 1'b0; flush2 = 1'b0; flush_pc2 = '0;
      bus2.rvalid = 1'b0; bus2.rdata = '0;
      test_reset();
      test_wait_states();
      test_stall();
      test_back_to_back();
      test_flush_outstanding();
      test_flush_stall_rvalid();
      test_reset_mid_request();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
